serializer_tx: RTL and testbench

SERIALIZER_TX -- requirements
Module: serializer_tx

---
 rtl/serializer_tx_if.sv | 28 ++
 rtl/serializer_tx.sv | 102 ++++++++++
 tb/tb_serializer_tx.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serializer_tx_if.sv
// Parallel-in / serial-out handshake bundle for serializer_tx.
// master: the word producer; slave: the serializer itself.
interface serializer_tx_if;
    logic [7:0] DIN;
    logic       DIN_VALID;
    logic       DIN_READY;
    logic       SER_OUT;
    logic       SER_ACTIVE;
    logic [2:0] FIFO_LEVEL;

    modport master (
        output DIN,
        output DIN_VALID,
        input  DIN_READY,
        input  SER_OUT,
        input  SER_ACTIVE,
        input  FIFO_LEVEL
    );

    modport slave (
        input  DIN,
        input  DIN_VALID,
        output DIN_READY,
        output SER_OUT,
        output SER_ACTIVE,
        output FIFO_LEVEL
    );
endinterface

// File: rtl/serializer_tx.sv
// Byte serializer: 4-deep word FIFO feeding an 8-bit shift register that emits
// one bit per clock. Consecutive words stream back-to-back with no idle gap.
module serializer_tx #(
    parameter logic IDLE_BIT  = 1'b0,
    parameter bit   MSB_FIRST = 1'b1
) (
    input logic            CLK,
    input logic            RST,
    serializer_tx_if.slave bus_io
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StShift = 1'b1;

    logic [0:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] level_q, level_d;
    logic [7:0] mem_q [4];

    logic din_ready;
    logic push;
    logic pop;

    // Ready depends only on the registered level, never on this cycle's pop.
    assign din_ready = (level_q < 3'd4);
    assign push      = bus_io.DIN_VALID && din_ready;
    // Fetch a word when idle, or on the last bit of the current word.
    assign pop       = (level_q != 3'd0) && ((state_q == StIdle) || (cnt_q == 3'd7));

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + 3'd1;
            2'b01:   level_d = level_q - 3'd1;
            default: level_d = level_q;
        endcase
    end

    // Shifter FSM: load on pop, otherwise shift one position per clock.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (pop) begin
            state_d = StShift;
            cnt_d   = 3'd0;
            shreg_d = mem_q[rd_ptr_q];
        end else if (state_q == StShift) begin
            cnt_d   = cnt_q + 3'd1;
            shreg_d = MSB_FIRST ? {shreg_q[6:0], 1'b0} : {1'b0, shreg_q[7:1]};
            if (cnt_q == 3'd7) begin
                state_d = StIdle;
            end
        end
    end

    // Control state with synchronous reset; reset also wins over a push.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            cnt_q    <= 3'd0;
            shreg_q  <= 8'd0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            level_q  <= 3'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // FIFO storage; contents are left as-is by reset.
    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            mem_q[wr_ptr_q] <= bus_io.DIN;
        end
    end

    assign bus_io.DIN_READY  = din_ready;
    assign bus_io.FIFO_LEVEL = level_q;
    assign bus_io.SER_ACTIVE = (state_q == StShift);
    assign bus_io.SER_OUT    = (state_q == StShift)
                               ? (MSB_FIRST ? shreg_q[7] : shreg_q[0])
                               : IDLE_BIT;

endmodule

// File: tb/tb_serializer_tx.sv
// Bench for serializer_tx: an MSB-first/IDLE_BIT=0 instance and an
// LSB-first/IDLE_BIT=1 instance share the same stimulus. A queue-based model
// of the word stream predicts every output each cycle; directed scenarios pin
// literal bit patterns.
module tb_serializer_tx;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    serializer_tx_if bus_a ();
    serializer_tx_if bus_b ();

    serializer_tx #(.IDLE_BIT(1'b0), .MSB_FIRST(1'b1)) dut_a (
        .CLK    (CLK),
        .RST    (RST),
        .bus_io (bus_a)
    );

    serializer_tx #(.IDLE_BIT(1'b1), .MSB_FIRST(1'b0)) dut_b (
        .CLK    (CLK),
        .RST    (RST),
        .bus_io (bus_b)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: buffered words plus the word on the wire.
    logic [7:0] fifo_m[$];
    logic [7:0] cur_m = 8'd0;
    int         bits_left = 0;
    bit         chk_en = 1'b0;

    // Literal expectations posted by the stimulus, checked by the compare process.
    string       lit_name [256];
    logic [15:0] lit_act  [256];
    logic [15:0] lit_exp  [256];
    int          lit_n = 0;
    int          lit_done = 0;

    // Captured serial data (written by the compare process only).
    logic [7:0]  out_a[$];
    logic [7:0]  out_b[$];
    logic [15:0] sa = 16'd0;
    logic [15:0] sb = 16'd0;
    logic [7:0]  wa = 8'd0;
    logic [7:0]  wb = 8'd0;
    int          na = 0;
    int          nb = 0;
    int          act_bits = 0;

    function automatic logic exp_ser(input bit msb, input logic idle_bit);
        int idx;
        if (bits_left == 0) return idle_bit;
        idx = 8 - bits_left;
        return msb ? cur_m[7 - idx] : cur_m[idx];
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: model versus both DUTs every cycle, plus posted literals.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("ready_a",  16'(bus_a.DIN_READY),  16'(fifo_m.size() < 4));
            check("level_a",  16'(bus_a.FIFO_LEVEL), 16'(fifo_m.size()));
            check("active_a", 16'(bus_a.SER_ACTIVE), 16'(bits_left > 0));
            check("ser_a",    16'(bus_a.SER_OUT),    16'(exp_ser(1'b1, 1'b0)));
            check("ready_b",  16'(bus_b.DIN_READY),  16'(fifo_m.size() < 4));
            check("level_b",  16'(bus_b.FIFO_LEVEL), 16'(fifo_m.size()));
            check("active_b", 16'(bus_b.SER_ACTIVE), 16'(bits_left > 0));
            check("ser_b",    16'(bus_b.SER_OUT),    16'(exp_ser(1'b0, 1'b1)));
        end
        while (lit_done < lit_n) begin
            check(lit_name[lit_done], lit_act[lit_done], lit_exp[lit_done]);
            lit_done++;
        end
        if (bus_a.SER_ACTIVE) begin
            act_bits++;
            sa = {sa[14:0], bus_a.SER_OUT};
            wa = {wa[6:0], bus_a.SER_OUT};
            na++;
            if (na == 8) begin
                out_a.push_back(wa);
                na = 0;
            end
        end else begin
            na = 0;
        end
        if (bus_b.SER_ACTIVE) begin
            sb = {sb[14:0], bus_b.SER_OUT};
            wb = {bus_b.SER_OUT, wb[7:1]};
            nb++;
            if (nb == 8) begin
                out_b.push_back(wb);
                nb = 0;
            end
        end else begin
            nb = 0;
        end
    end

    task automatic post(input string name, input logic [15:0] act, input logic [15:0] exp);
        lit_name[lit_n] = name;
        lit_act[lit_n]  = act;
        lit_exp[lit_n]  = exp;
        lit_n++;
    endtask

    // Model of one clock edge: pop (from the pre-edge contents) then push.
    task automatic model_step(input logic rst, input logic vld, input logic [7:0] d);
        bit push;
        if (rst) begin
            fifo_m.delete();
            bits_left = 0;
        end else begin
            push = vld && (fifo_m.size() < 4);
            if (bits_left <= 1 && fifo_m.size() > 0) begin
                cur_m = fifo_m.pop_front();
                bits_left = 8;
            end else if (bits_left > 0) begin
                bits_left--;
            end
            if (push) fifo_m.push_back(d);
        end
    endtask

    task automatic cycle(input logic rst, input logic vld, input logic [7:0] d);
        RST             = rst;
        bus_a.DIN_VALID = vld;
        bus_a.DIN       = d;
        bus_b.DIN_VALID = vld;
        bus_b.DIN       = d;
        @(posedge CLK);
        model_step(rst, vld, d);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'($urandom_range(0, 255)));
    endtask

    initial begin
        int base;
        int w;
        int ee;
        bit saw_full;
        RST = 1'b1;
        bus_a.DIN_VALID = 1'b0;
        bus_a.DIN = 8'd0;
        bus_b.DIN_VALID = 1'b0;
        bus_b.DIN = 8'd0;

        // Reset state
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'h77);
        chk_en = 1'b1;
        post("rst_ready", 16'(bus_a.DIN_READY), 16'd1);
        post("rst_level", 16'(bus_a.FIFO_LEVEL), 16'd0);
        post("rst_ser_a", 16'(bus_a.SER_OUT), 16'd0);
        post("rst_ser_b", 16'(bus_b.SER_OUT), 16'd1);
        post("rst_active", 16'(bus_a.SER_ACTIVE), 16'd0);

        // Single word 0xD5 with latency pin
        base = act_bits;
        cycle(1'b0, 1'b1, 8'hD5);
        post("lat_not_yet", 16'(bus_a.SER_ACTIVE), 16'd0);
        cycle(1'b0, 1'b0, 8'h00);
        post("lat_first", 16'(bus_a.SER_ACTIVE), 16'd1);
        idle(12);
        post("single_bits_a", 16'(sa[7:0]), 16'h00D5);
        post("single_bits_b", 16'(sb[7:0]), 16'h00AB);
        post("single_count", 16'(act_bits - base), 16'd8);

        // Back-to-back 0xD5, 0x2A
        base = act_bits;
        cycle(1'b0, 1'b1, 8'hD5);
        cycle(1'b0, 1'b1, 8'h2A);
        idle(20);
        post("b2b_bits_a", sa, 16'hD52A);
        post("b2b_bits_b", sb, 16'hAB54);
        post("b2b_count", 16'(act_bits - base), 16'd16);

        // LSB-first pattern for 0xAB is 1,1,0,1,0,1,0,1
        cycle(1'b0, 1'b1, 8'hAB);
        idle(12);
        post("lsb_ab", 16'(sb[7:0]), 16'h00D5);

        // Backpressure with words 1..6
        base = out_a.size();
        w = 1;
        saw_full = 1'b0;
        for (int t = 0; t < 200 && w <= 6; t++) begin
            bit acc;
            acc = (fifo_m.size() < 4);
            cycle(1'b0, 1'b1, 8'(w));
            if (acc) w++;
            if (!saw_full && fifo_m.size() == 4) begin
                saw_full = 1'b1;
                post("bp_level4", 16'(bus_a.FIFO_LEVEL), 16'd4);
                post("bp_ready0", 16'(bus_a.DIN_READY), 16'd0);
            end
        end
        idle(70);
        post("bp_full_seen", 16'(saw_full), 16'd1);
        post("bp_nwords", 16'(out_a.size() - base), 16'd6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < out_a.size()) begin
                post("bp_word_a", 16'(out_a[base + i]), 16'(i + 1));
                post("bp_word_b", 16'(out_b[base + i]), 16'(i + 1));
            end
        end
        post("bp_drained", 16'(bus_a.FIFO_LEVEL), 16'd0);

        // Ignored handshake: 0xEE offered only while full
        base = out_a.size();
        w = 8'h11;
        for (int t = 0; t < 50 && fifo_m.size() < 4; t++) begin
            cycle(1'b0, 1'b1, 8'(w));
            w++;
        end
        for (int t = 0; t < 3 && fifo_m.size() == 4; t++) cycle(1'b0, 1'b1, 8'hEE);
        idle(60);
        ee = 0;
        for (int i = base; i < out_a.size(); i++) if (out_a[i] == 8'hEE) ee++;
        post("no_ee", 16'(ee), 16'd0);

        // Reset mid-word: 3 bits of 0xFF out, two words buffered, reset with push
        base = out_a.size();
        cycle(1'b0, 1'b1, 8'hFF);
        cycle(1'b0, 1'b1, 8'h33);
        cycle(1'b0, 1'b1, 8'h44);
        post("mid_level2", 16'(bus_a.FIFO_LEVEL), 16'd2);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'h55);
        post("mid_ser", 16'(bus_a.SER_OUT), 16'd0);
        post("mid_level", 16'(bus_a.FIFO_LEVEL), 16'd0);
        post("mid_ready", 16'(bus_a.DIN_READY), 16'd1);
        post("mid_active", 16'(bus_a.SER_ACTIVE), 16'd0);
        idle(20);
        post("mid_no_words", 16'(out_a.size() - base), 16'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 60),
                  8'($urandom_range(0, 255)));
        end
        idle(50);

        @(negedge CLK);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
